// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO read-side consumer that serialises each popped byte as an 8N1 UART frame
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_data,
  output logic        tx,
  output logic        busy,
  output logic [15:0] bytes_sent
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LATCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] bytes_q, bytes_d;
  logic        tx_q, tx_d;
  logic        rd_en_q, rd_en_d;

  logic baud_last;
  logic start_ok;

  assign baud_last = (baud_q == BAUD_LAST);
  assign start_ok  = enable && !fifo_empty;

  // Next-state logic; tx and the read strobe are decoded from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bytes_d = bytes_q;

    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // FIFO output is valid the cycle after the pop strobe
        shift_d = fifo_data;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = 16'd0;
          bytes_d = bytes_q + 16'd1;
          // A push that arrived mid-frame is picked up here without returning to IDLE
          state_d = start_ok ? S_POP : S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    rd_en_d = (state_d == S_POP);
  end

  // State, counters and registered outputs; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      bytes_q <= 16'd0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bytes_q <= bytes_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign busy       = (state_q != S_IDLE);
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a queue-based FIFO and frame-level reference
module tb_fifo_uart_tx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;

  logic [7:0] fifo_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  exp;     // {tx, fifo_rd_en, busy}
    logic [15:0] exp_bs;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .tx         (tx),
    .busy       (busy),
    .bytes_sent (bytes_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock, sampling at the falling edge; the FIFO model pops on a seen read strobe
  task automatic step();
    @(negedge clk);
    if (fifo_rd_en === 1'b1) begin
      check("no_underflow", {31'd0, fifo_q.size() != 0}, 32'd1);
      if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic frame_level(input logic [7:0] b, input int k);
    logic lvl;
    if (k == 0)      lvl = 1'b0;
    else if (k == 9) lvl = 1'b1;
    else             lvl = b[k-1];
    return lvl;
  endfunction

  // Expected line activity for bytes sent back to back from IDLE: POP, LATCH, then 10 bit periods per byte
  task automatic check_burst(input logic [7:0] bl[$], input int base, input int drop, input int tail);
    logic [2:0] exp[$];
    logic [7:0] b;
    for (int j = 0; j < bl.size(); j++) begin
      b = bl[j];
      exp.push_back(3'b111);
      exp.push_back(3'b101);
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < N; c++)
          exp.push_back({frame_level(b, k), 1'b0, 1'b1});
    end
    for (int t = 0; t < tail; t++) exp.push_back(3'b100);
    enable = 1'b1;
    for (int i = 0; i < exp.size(); i++) begin
      if (i == drop) enable = 1'b0;
      step();
      check($sformatf("burst_b%0d_cyc%0d", base, i), {29'd0, tx, fifo_rd_en, busy}, {29'd0, exp[i]});
    end
    check("burst_bytes_sent", {16'd0, bytes_sent}, base + bl.size());
  endtask

  initial begin
    logic [7:0] lst[$];
    logic [7:0] one[$];
    logic [7:0] b;
    int total;
    int nb;

    rst        = 1'b1;
    enable     = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;

    // Reset held with enable high and a byte waiting, then a single 0xA5 frame
    push(8'hA5);
    for (int i = 0; i < 3; i++) tv.push_back('{1'b1, 1'b1, 3'b100, 16'd0});
    tv.push_back('{1'b0, 1'b1, 3'b111, 16'd0});
    tv.push_back('{1'b0, 1'b1, 3'b101, 16'd0});
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < N; c++)
        tv.push_back('{1'b0, 1'b1, {frame_level(8'hA5, k), 1'b0, 1'b1}, 16'd0});
    tv.push_back('{1'b0, 1'b1, 3'b100, 16'd1});
    tv.push_back('{1'b0, 1'b1, 3'b100, 16'd1});

    for (int i = 0; i < tv.size(); i++) begin
      rst    = tv[i].rst;
      enable = tv[i].en;
      step();
      check($sformatf("vec%0d_out", i), {29'd0, tx, fifo_rd_en, busy}, {29'd0, tv[i].exp});
      check($sformatf("vec%0d_bytes", i), {16'd0, bytes_sent}, {16'd0, tv[i].exp_bs});
    end

    // Three queued bytes go out with 2-cycle gaps and no pop once empty
    do_reset();
    lst = '{8'h00, 8'hFF, 8'h3C};
    foreach (lst[i]) push(lst[i]);
    check_burst(lst, 0, -1, 4);

    // Full FIFO held back by enable=0, then drained in push order
    do_reset();
    lst.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      lst.push_back(b);
      push(b);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold_cyc%0d", i), {29'd0, tx, fifo_rd_en, busy}, 32'b100);
    end
    check_burst(lst, 0, -1, 3);
    check("fifo_drained_8", fifo_q.size(), 32'd0);

    // Enable dropped mid-DATA: current frame completes, nothing more until enable returns
    do_reset();
    lst.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      lst.push_back(b);
      push(b);
    end
    one = '{lst[0]};
    check_burst(one, 0, 14, 12);
    check("pending_after_drop", fifo_q.size(), 32'd2);
    lst = lst[1:2];
    check_burst(lst, 1, -1, 3);

    // Reset during data bit 4 drops the popped byte; the next queued byte goes out cleanly
    do_reset();
    lst.delete();
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      lst.push_back(b);
      push(b);
    end
    enable = 1'b1;
    for (int i = 0; i < 2 + 5 * N + 1; i++) step();
    rst = 1'b1;
    step();
    check("midreset_out", {29'd0, tx, fifo_rd_en, busy}, 32'b100);
    check("midreset_bytes", {16'd0, bytes_sent}, 32'd0);
    rst = 1'b0;
    one = '{lst[1]};
    check_burst(one, 0, -1, 3);
    check("fifo_drained_rst", fifo_q.size(), 32'd0);

    // Random bursts with bytes_sent accumulating across them
    do_reset();
    total = 0;
    for (int r = 0; r < 5; r++) begin
      nb = $urandom_range(1, 4);
      lst.delete();
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom);
        lst.push_back(b);
        push(b);
      end
      check_burst(lst, total, -1, 3);
      total += nb;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
